seq_detect_param: RTL and testbench

- Parametrised serial bit-pattern detector; successor to the fixed 3-bit-state sequence detector FSM.
- Pattern length is set by parameter. The pattern itself and the overlap mode are run-time programmable.
- Accepts one qualified input bit per cycle. Emits a registered one-cycle match pulse, a fill-level state output and a saturating match counter.
- Sits between the serial front end and the control logic that consumes detection events.

---
 rtl/seq_detect_pkg.sv | 11 +
 rtl/seq_sat_counter.sv | 22 ++
 rtl/seq_detect_param.sv | 115 +++++++++++
 tb/tb_seq_detect_param.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
package seq_detect_pkg;

  localparam logic OVL_ON  = 1'b1;
  localparam logic OVL_OFF = 1'b0;

  function automatic int fill_w(input int pat_len);
    return $clog2(pat_len + 1);
  endfunction

endpackage

// File: rtl/seq_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at all-ones.
module seq_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX = '1;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector with programmable pattern/overlap and a saturating match count.
// Optional don't-care mask per pattern bit when SEQ_DETECT_MASK_EN is defined.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int                 PAT_LEN   = 8,
  parameter logic [PAT_LEN-1:0] PAT_RESET = 8'b01110010,
  parameter logic               OVL_RESET = 1'b1,
  parameter int                 CNT_W     = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic                        in,
  input  logic                        cfg_load,
  input  logic [PAT_LEN-1:0]          cfg_pattern,
  input  logic                        cfg_overlap,
`ifdef SEQ_DETECT_MASK_EN
  input  logic [PAT_LEN-1:0]          cfg_mask,
`endif
  output logic                        out,
  output logic [fill_w(PAT_LEN)-1:0]  state,
  output logic [CNT_W-1:0]            match_cnt
);

  localparam int            FW   = fill_w(PAT_LEN);
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN);

  logic [PAT_LEN-1:0] pattern;
  logic               overlap;
  logic [PAT_LEN-1:0] mask_eff;
  logic [PAT_LEN-1:0] hist;
  logic [PAT_LEN-1:0] hist_shift;
  logic [PAT_LEN-1:0] hist_nxt;
  logic [FW-1:0]      fill_inc;
  logic [FW-1:0]      state_nxt;
  logic               pattern_ok;
  logic               out_nxt;

  // Configuration registers; a load also restarts detection (see state logic).
`ifdef SEQ_DETECT_MASK_EN
  logic [PAT_LEN-1:0] mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      mask <= '0;
    end else if (cfg_load) begin
      mask <= cfg_mask;
    end
  end

  assign mask_eff = mask;
`else
  assign mask_eff = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern <= PAT_RESET;
      overlap <= OVL_RESET;
    end else if (cfg_load) begin
      pattern <= cfg_pattern;
      overlap <= cfg_overlap;
    end
  end

  assign hist_shift = {hist[PAT_LEN-2:0], in};
  assign fill_inc   = (state == FULL) ? FULL : state + FW'(1);
  assign pattern_ok = ((hist_shift ^ pattern) & ~mask_eff) == '0;

  // state | meaning
  // 0..PAT_LEN-1 | FILL_n: n valid bits collected, window not yet full
  // PAT_LEN      | FILL_PAT_LEN: window full, every valid bit is compared
  always_ff @(posedge clk) begin
    if (reset) begin
      hist  <= '0;
      state <= '0;
      out   <= 1'b0;
    end else begin
      hist  <= hist_nxt;
      state <= state_nxt;
      out   <= out_nxt;
    end
  end

  always_comb begin
    hist_nxt  = hist;
    state_nxt = state;
    if (cfg_load) begin
      hist_nxt  = '0;
      state_nxt = '0;
    end else if (in_valid) begin
      hist_nxt  = hist_shift;
      state_nxt = (out_nxt && (overlap == OVL_OFF)) ? '0 : fill_inc;
    end
  end

  always_comb begin
    out_nxt = 1'b0;
    if (!cfg_load && in_valid && (fill_inc == FULL) && pattern_ok) begin
      out_nxt = 1'b1;
    end
  end

  seq_sat_counter #(
    .WIDTH (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cfg_load),
    .inc   (out_nxt),
    .count (match_cnt)
  );

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed self-checking bench for seq_detect_param (PAT_LEN=4, CNT_W=2).
module tb_seq_detect_param;

  localparam int PAT_LEN = 4;
  localparam int CNT_W   = 2;
  localparam int FW      = 3;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic               in;
  logic               cfg_load;
  logic [PAT_LEN-1:0] cfg_pattern;
  logic               cfg_overlap;
`ifdef SEQ_DETECT_MASK_EN
  logic [PAT_LEN-1:0] cfg_mask;
`endif
  logic               out;
  logic [FW-1:0]      state;
  logic [CNT_W-1:0]   match_cnt;

  int errors = 0;
  int checks = 0;

  seq_detect_param #(
    .PAT_LEN   (PAT_LEN),
    .PAT_RESET (4'b1010),
    .OVL_RESET (1'b1),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in          (in),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_overlap (cfg_overlap),
`ifdef SEQ_DETECT_MASK_EN
    .cfg_mask    (cfg_mask),
`endif
    .out         (out),
    .state       (state),
    .match_cnt   (match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic b);
    @(negedge clk);
    reset    = 1'b0;
    cfg_load = 1'b0;
    in_valid = v;
    in       = b;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [PAT_LEN-1:0] p, input logic o, input logic [PAT_LEN-1:0] m,
                      input logic v, input logic b);
    @(negedge clk);
    reset       = 1'b0;
    cfg_load    = 1'b1;
    cfg_pattern = p;
    cfg_overlap = o;
`ifdef SEQ_DETECT_MASK_EN
    cfg_mask    = m;
`else
    if (m != '0) $display("note: mask ignored in this build");
`endif
    in_valid    = v;
    in          = b;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset(input logic v, input logic b);
    @(negedge clk);
    reset    = 1'b1;
    cfg_load = 1'b0;
    in_valid = v;
    in       = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0]  stream;
    logic [6:0]  exp_out;
    logic [20:0] exp_st;
    logic [3:0]  gap_bits;
    logic [7:0]  sat_out;
    logic [15:0] sat_cnt;

    reset       = 1'b1;
    in_valid    = 1'b0;
    in          = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = '0;
    cfg_overlap = 1'b0;
`ifdef SEQ_DETECT_MASK_EN
    cfg_mask    = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", out, 0);
    chk("rst_state", state, 0);
    chk("rst_cnt", match_cnt, 0);

    // Overlapping: 1101101 against 1101 -> pulses after bits 4 and 7.
    stream  = 7'b1101101;
    exp_out = 7'b0001001;
    exp_st  = {3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4};
    load(4'b1101, 1'b1, 4'b0000, 1'b0, 1'b0);
    chk("ovl_load_state", state, 0);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, stream[6-i]);
      chk("ovl_out", out, exp_out[6-i]);
      chk("ovl_state", state, exp_st[3*(6-i) +: 3]);
    end
    chk("ovl_cnt", match_cnt, 2);

    // Non-overlapping: same stream -> one pulse, fill restarts after it.
    exp_out = 7'b0001000;
    exp_st  = {3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3};
    load(4'b1101, 1'b0, 4'b0000, 1'b0, 1'b0);
    chk("novl_load_cnt", match_cnt, 0);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, stream[6-i]);
      chk("novl_out", out, exp_out[6-i]);
      chk("novl_state", state, exp_st[3*(6-i) +: 3]);
    end
    chk("novl_cnt", match_cnt, 1);

    // Gapped: two idle cycles after every valid bit.
    gap_bits = 4'b1101;
    load(4'b1101, 1'b1, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, gap_bits[3-i]);
      chk("gap_valid_out", out, (i == 3) ? 1 : 0);
      for (int g = 0; g < 2; g++) begin
        step(1'b0, ~gap_bits[3-i]);
        chk("gap_idle_out", out, 0);
        chk("gap_idle_state", state, i + 1);
      end
    end
    chk("gap_cnt", match_cnt, 1);

    // Mid-stream reconfig with a concurrent valid bit that must be dropped.
    load(4'b1101, 1'b1, 4'b0000, 1'b0, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    chk("recfg_pre_state", state, 3);
    load(4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1);
    chk("recfg_state", state, 0);
    chk("recfg_cnt", match_cnt, 0);
    chk("recfg_out", out, 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      chk("recfg_out_zeros", out, (i == 3) ? 1 : 0);
    end
    chk("recfg_cnt_after", match_cnt, 1);
    // Load while out is high: pulse ends, nothing follows from old history.
    load(4'b1101, 1'b1, 4'b0000, 1'b0, 1'b0);
    chk("load_during_pulse_out", out, 0);
    chk("load_during_pulse_state", state, 0);
    step(1'b1, 1'b1);
    chk("load_during_pulse_next", out, 0);

    // Saturation: eight 1s against 1111 -> 5 matches, count sticks at 3.
    sat_out = 8'b00011111;
    sat_cnt = {2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    load(4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1);
      chk("sat_out", out, sat_out[7-i]);
      chk("sat_cnt", match_cnt, sat_cnt[2*(7-i) +: 2]);
    end

    // Reset mid-stream: everything clears and pattern reverts to 1010.
    pulse_reset(1'b1, 1'b1);
    chk("mrst_out", out, 0);
    chk("mrst_state", state, 0);
    chk("mrst_cnt", match_cnt, 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1);
      chk("mrst_ones_out", out, 0);
    end
    chk("mrst_state_full", state, 4);
    step(1'b1, 1'b1);
    chk("mrst_1010_b0", out, 0);
    step(1'b1, 1'b0);
    chk("mrst_1010_b1", out, 0);
    step(1'b1, 1'b1);
    chk("mrst_1010_b2", out, 0);
    step(1'b1, 1'b0);
    chk("mrst_1010_hit", out, 1);
    chk("mrst_1010_cnt", match_cnt, 1);
    step(1'b0, 1'b0);
    chk("mrst_idle_out", out, 0);

`ifdef SEQ_DETECT_MASK_EN
    // Bit 1 of the pattern is don't-care: 1111 matches, 1100 does not.
    load(4'b1101, 1'b1, 4'b0010, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1);
      chk("mask_1111_out", out, (i == 3) ? 1 : 0);
    end
    load(4'b1101, 1'b1, 4'b0010, 1'b0, 1'b0);
    gap_bits = 4'b1100;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, gap_bits[3-i]);
      chk("mask_1100_out", out, 0);
    end
    chk("mask_cnt", match_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
